// File: rtl/sram_freeze_controller_pkg.sv
// Shared constants for the SRAM freeze controller.
// State encoding and SRAM geometry live here.
package sram_freeze_controller_pkg;

  localparam int DATA_LEN      = 32;
  localparam int SRAM_DATA_LEN = DATA_LEN / 2;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int BASE_ADDR     = 1024;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/sram_freeze_controller_phase_counter.sv
// Wait-cycle counter for one half-word phase.
// Saturates at WAIT_CYCLES-1 and flags the last cycle.
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic last
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_VAL);

  // Next count: restart on phase entry, hold once the last cycle is hit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (!last)
      cnt_d = cnt_q + CW'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sram_freeze_controller.sv
// Memory-stage controller: 32-bit accesses over a 16-bit SRAM.
// Drives ready low (freeze) until both half-word phases finish.
module sram_freeze_controller
  import sram_freeze_controller_pkg::*;
#(
  parameter int DATA_LEN      = sram_freeze_controller_pkg::DATA_LEN,
  parameter int SRAM_DATA_LEN = sram_freeze_controller_pkg::SRAM_DATA_LEN,
  parameter int SRAM_ADDR_LEN = sram_freeze_controller_pkg::SRAM_ADDR_LEN,
  parameter int BASE_ADDR     = sram_freeze_controller_pkg::BASE_ADDR,
  parameter int WAIT_CYCLES   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_r_en,
  input  logic                     mem_w_en,
  input  logic [DATA_LEN-1:0]      addr,
  input  logic [DATA_LEN-1:0]      write_data,
  output logic [DATA_LEN-1:0]      read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_we_n
);

  localparam int WL = SRAM_ADDR_LEN - 1;
  localparam int HL = SRAM_DATA_LEN;

  logic [1:0]          state_q, state_d;
  logic                wr_q, wr_d;
  logic [WL-1:0]       word_q, word_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic                req, last, clr, busy, hi, drv;

  assign req = mem_r_en | mem_w_en;

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .last(last)
  );

  // FSM next state, request latching and load-data capture.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          wr_d    = mem_w_en;
          word_d  = WL'((addr - DATA_LEN'(BASE_ADDR)) >> 2);
          wdata_d = write_data;
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          if (!wr_q)
            rdata_d[HL-1:0] = sram_dq_in;
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          if (!wr_q)
            rdata_d[DATA_LEN-1:HL] = sram_dq_in;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Restart the phase counter whenever the state changes.
  always_comb begin
    clr = (state_d != state_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins and freeze handshake; idle pins rest at zero.
  always_comb begin
    busy = (state_q == S_LOW) | (state_q == S_HIGH);
    hi   = (state_q == S_HIGH);
    drv  = busy & wr_q;
    if (state_q == S_IDLE)
      ready = ~req;
    else
      ready = ~busy;
    sram_we_n  = ~drv;
    sram_dq_oe = drv;
    sram_addr  = busy ? {word_q, hi} : '0;
    if (!drv)
      sram_dq_out = '0;
    else if (hi)
      sram_dq_out = wdata_q[DATA_LEN-1:HL];
    else
      sram_dq_out = wdata_q[HL-1:0];
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_freeze_controller.sv
// Scoreboard bench for sram_freeze_controller.
// Per-cycle expectations are queued at request time.
module tb_sram_freeze_controller;

  localparam int W = 3;

  typedef struct packed {
    logic        rdy;
    logic        we_n;
    logic        oe;
    logic        chk_a;
    logic [17:0] a;
    logic        chk_dq;
    logic [15:0] dq;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int n_chk = 0;
  int n_pass = 0;
  exp_t q[$];

  logic [15:0] mem [logic [17:0]];
  logic [17:0] last_a_q = '0;
  int          age_q = 0;
  int          age;

  always #5 clk = ~clk;

  sram_freeze_controller #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  // Slow SRAM: data is valid only after the address is stable W cycles.
  always_comb begin
    age = (sram_addr == last_a_q) ? age_q + 1 : 1;
    sram_dq_in = 16'hBAD0;
    if (age >= W && mem.exists(sram_addr))
      sram_dq_in = mem[sram_addr];
  end

  always @(posedge clk) begin
    last_a_q <= sram_addr;
    age_q    <= age;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cmp(input exp_t e);
    check("ready", 32'(ready), 32'(e.rdy));
    check("we_n", 32'(sram_we_n), 32'(e.we_n));
    check("dq_oe", 32'(sram_dq_oe), 32'(e.oe));
    if (e.chk_a)
      check("sram_addr", 32'(sram_addr), 32'(e.a));
    if (e.chk_dq)
      check("dq_out", 32'(sram_dq_out), 32'(e.dq));
    if (e.chk_rd)
      check("read_data", read_data, e.rd);
  endtask

  task automatic do_access(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [17:0] a0,
                           input logic [31:0] rd,
                           input logic keep);
    exp_t e;
    bit first;
    e = '0;
    e.we_n = 1'b1;
    q.push_back(e);
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c < W; c++) begin
        e = '0;
        e.we_n = ~w;
        e.oe = w;
        e.chk_a = 1'b1;
        e.a = a0 + 18'(h);
        e.chk_dq = w;
        e.dq = (h == 1) ? d[31:16] : d[15:0];
        q.push_back(e);
      end
    end
    e = '0;
    e.rdy = 1'b1;
    e.we_n = 1'b1;
    e.chk_rd = 1'b1;
    e.rd = rd;
    q.push_back(e);

    @(posedge clk); #1;
    mem_r_en = r;
    mem_w_en = w;
    addr = a;
    write_data = d;
    first = 1'b1;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      cmp(e);
      if (q.size() > 0) begin
        @(posedge clk); #1;
        if (first) begin
          addr = ~a;
          write_data = ~d;
          first = 1'b0;
        end
      end
    end
    if (!keep) begin
      @(posedge clk); #1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("rd_hold", read_data, rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    mem[18'd4] = 16'h5678;
    mem[18'd5] = 16'h1234;
    mem[18'h3FFFE] = 16'hAAAA;
    mem[18'h3FFFF] = 16'h5555;

    #1;
    check("rst_rd", read_data, 32'h0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq", 32'(sram_dq_out), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4,
              32'h0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 18'd4,
              32'h12345678, 1'b0);
    do_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4,
              32'h12345678, 1'b0);
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4,
              32'h12345678, 1'b0);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 18'd4,
              32'h12345678, 1'b1);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 18'd4,
              32'h12345678, 1'b0);
    do_access(1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 18'h3FFFE,
              32'h12345678, 1'b0);
    do_access(1'b1, 1'b0, 32'd1020, 32'h0, 18'h3FFFE,
              32'h5555AAAA, 1'b0);

    @(posedge clk); #1;
    mem_w_en = 1'b1;
    addr = 32'd1032;
    write_data = 32'h13572468;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_addr", 32'(sram_addr), 32'd5);
    check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_we_n", 32'(sram_we_n), 32'd1);
    check("arst_oe", 32'(sram_dq_oe), 32'd0);
    check("arst_rd", read_data, 32'h0);
    mem_w_en = 1'b0;
    @(posedge clk); #1;
    check("arst_we_hold", 32'(sram_we_n), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_we_n", 32'(sram_we_n), 32'd1);
    check("post_rst_rd", read_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
